// File: rtl/gauss_pkg.sv
// Shared encodings for the separable 1-2-1 Gaussian engine: FSM states,
// operating modes and frame-buffer selects.
package gauss_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HPASS,
    ST_VPASS,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] MODE_H  = 2'd0;
  localparam logic [1:0] MODE_V  = 2'd1;
  localparam logic [1:0] MODE_HV = 2'd2;

  localparam logic [1:0] BUF_IN  = 2'd0;
  localparam logic [1:0] BUF_TMP = 2'd1;
  localparam logic [1:0] BUF_OUT = 2'd2;
endpackage

// File: rtl/gauss3_tap.sv
// Sliding 3-pixel window with edge replication and a registered 1-2-1 filter.
// One result per incoming pixel after the first, plus one flush result at line end.
module gauss3_tap #(
  parameter int PIX_W = 8,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             first,
  input  logic             last,
  input  logic [PIX_W-1:0] din,
  output logic             out_vld,
  output logic [PIX_W-1:0] out_data
);
  localparam logic [PIX_W+1:0] RND = (ROUND != 0) ? (PIX_W+2)'(2) : '0;

  logic [PIX_W-1:0] r1, r2, c;
  logic [PIX_W+1:0] sum;
  logic             flush, emit;

  // r1 = pixel[j-1], r2 = pixel[j-2]; the flush cycle replicates the last pixel as c
  assign c    = flush ? r1 : din;
  assign sum  = {2'b00, r2} + {1'b0, r1, 1'b0} + {2'b00, c} + RND;
  assign emit = flush | (shift & ~first);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1       <= '0;
      r2       <= '0;
      flush    <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      flush   <= shift & last & ~clr;
      out_vld <= emit & ~clr;
      if (emit) out_data <= sum[PIX_W+1:2];
      if (shift) begin
        r2 <= first ? din : r1;
        r1 <= din;
      end
    end
  end
endmodule

// File: rtl/gauss3_sep_engine.sv
// Separable 3-tap Gaussian engine: sequences H and/or V passes over a BRAM frame,
// one read per pixel per pass, fixed line period of N+RD_LAT+2 cycles.
module gauss3_sep_engine
  import gauss_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 7,
  parameter int RD_LAT = 1,
  parameter int ROUND  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err_mode,
  output logic                   pass_v,
  output logic [1:0]             rd_sel,
  output logic [ROW_W+COL_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]       rd_data,
  output logic                   wr_en,
  output logic [1:0]             wr_sel,
  output logic [ROW_W+COL_W-1:0] wr_addr,
  output logic [PIX_W-1:0]       wr_data
);
  localparam int LW = ((COL_W > ROW_W) ? COL_W : ROW_W) + 2;
  localparam logic [LW-1:0] W_N  = LW'(2**COL_W);
  localparam logic [LW-1:0] H_N  = LW'(2**ROW_W);
  localparam logic [LW-1:0] ONE  = LW'(1);
  localparam logic [LW-1:0] TAIL = LW'(RD_LAT + 1);

  state_t          state;
  logic [1:0]      mode_q;
  logic [LW-1:0]   cyc, line, wk, n_len, n_lines, rd_idx;
  logic            in_pass, vp, line_end, last_line, rd_vld, abort_now;
  logic [RD_LAT:1] vld_pipe, first_pipe, last_pipe;
  logic            tap_vld;
  logic [PIX_W-1:0] tap_q;

  assign in_pass   = (state == ST_HPASS) || (state == ST_VPASS);
  assign vp        = (state == ST_VPASS);
  assign n_len     = vp ? H_N : W_N;
  assign n_lines   = vp ? W_N : H_N;
  assign line_end  = (cyc == n_len + TAIL);
  assign last_line = (line == n_lines - ONE);
  assign rd_vld    = in_pass && (cyc < n_len);
  assign abort_now = abort && in_pass;
  // clamp keeps the read address inside the line during the drain cycles
  assign rd_idx    = (cyc < n_len) ? cyc : n_len - ONE;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE) || (state == ST_ERR);
  assign pass_v  = vp;
  assign rd_sel  = (vp && mode_q == MODE_HV) ? BUF_TMP : BUF_IN;
  assign rd_addr = vp ? {ROW_W'(rd_idx), COL_W'(line)} : {ROW_W'(line), COL_W'(rd_idx)};
  assign wr_en   = tap_vld && in_pass;
  assign wr_sel  = !in_pass ? 2'd0 : (!vp && mode_q == MODE_HV) ? BUF_TMP : BUF_OUT;
  assign wr_addr = vp ? {ROW_W'(wk), COL_W'(line)} : {ROW_W'(line), COL_W'(wk)};
  assign wr_data = tap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      mode_q   <= '0;
      err_mode <= 1'b0;
      cyc      <= '0;
      line     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          mode_q   <= mode;
          err_mode <= (mode == 2'd3);
          cyc      <= '0;
          line     <= '0;
          case (mode)
            MODE_V:  state <= ST_VPASS;
            2'd3:    state <= ST_ERR;
            default: state <= ST_HPASS;
          endcase
        end
        ST_HPASS, ST_VPASS: begin
          if (abort) begin
            state <= ST_IDLE;
            cyc   <= '0;
            line  <= '0;
          end else if (line_end) begin
            cyc <= '0;
            if (last_line) begin
              line  <= '0;
              state <= (!vp && mode_q == MODE_HV) ? ST_VPASS : ST_DONE;
            end else begin
              line <= line + ONE;
            end
          end else begin
            cyc <= cyc + ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // read-valid pipeline aligned to BRAM latency; abort drops in-flight data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else if (abort_now) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe[1]   <= rd_vld;
      first_pipe[1] <= rd_vld && (cyc == '0);
      last_pipe[1]  <= rd_vld && (cyc == n_len - ONE);
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           wk <= '0;
    else if (abort_now) wk <= '0;
    else if (wr_en)     wk <= (wk == n_len - ONE) ? '0 : wk + ONE;
  end

  gauss3_tap #(.PIX_W(PIX_W), .ROUND(ROUND)) u_tap (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort_now),
    .shift    (vld_pipe[RD_LAT]),
    .first    (first_pipe[RD_LAT]),
    .last     (last_pipe[RD_LAT]),
    .din      (rd_data),
    .out_vld  (tap_vld),
    .out_data (tap_q)
  );
endmodule

// File: tb/tb_gauss3_sep_engine.sv
// Two 4x4 engines side by side: RD_LAT=1/truncate and RD_LAT=3/round-half-up,
// fed from one input image; a scoreboard checks every write of both.
module tb_gauss3_sep_engine;
  typedef logic [7:0] img_t [16];
  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] addr;
    logic [7:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [1:0] mode;
  logic [1:0] busy, done, err_mode, pass_v, wr_en;
  logic [1:0][1:0] rd_sel, wr_sel;
  logic [1:0][3:0] rd_addr, wr_addr;
  logic [1:0][7:0] wr_data;
  logic [7:0] rdd0, rdd1, p1a, p1b;

  img_t img;
  logic [7:0] mem [2][3][16];
  sb_t q[2][$];
  int done_cnt[2];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gauss3_sep_engine #(.PIX_W(8), .COL_W(2), .ROW_W(2), .RD_LAT(1), .ROUND(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy[0]), .done(done[0]), .err_mode(err_mode[0]), .pass_v(pass_v[0]),
    .rd_sel(rd_sel[0]), .rd_addr(rd_addr[0]), .rd_data(rdd0),
    .wr_en(wr_en[0]), .wr_sel(wr_sel[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]));

  gauss3_sep_engine #(.PIX_W(8), .COL_W(2), .ROW_W(2), .RD_LAT(3), .ROUND(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy[1]), .done(done[1]), .err_mode(err_mode[1]), .pass_v(pass_v[1]),
    .rd_sel(rd_sel[1]), .rd_addr(rd_addr[1]), .rd_data(rdd1),
    .wr_en(wr_en[1]), .wr_sel(wr_sel[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]));

  function automatic logic [7:0] rdmem(input int d, input logic [1:0] sel, input logic [3:0] a);
    return (sel == 2'd0) ? img[a] : mem[d][sel][a];
  endfunction

  // BRAM model: buffer 0 is the shared input image, 1/2 are per-engine
  always @(posedge clk) begin
    if (wr_en[0]) mem[0][wr_sel[0]][wr_addr[0]] <= wr_data[0];
    if (wr_en[1]) mem[1][wr_sel[1]][wr_addr[1]] <= wr_data[1];
    rdd0 <= rdmem(0, rd_sel[0], rd_addr[0]);
    p1a  <= rdmem(1, rd_sel[1], rd_addr[1]);
    p1b  <= p1a;
    rdd1 <= p1b;
  end

  initial begin : monitor
    sb_t it;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          if (wr_en[d]) begin
            checks++;
            if (q[d].size() == 0) begin
              fails++;
              $display("FAIL sb_dut%0d: unexpected write sel=%0d addr=%0d data=%0d",
                       d, wr_sel[d], wr_addr[d], wr_data[d]);
            end else begin
              it = q[d].pop_front();
              if (it != {wr_sel[d], wr_addr[d], wr_data[d]}) begin
                fails++;
                $display("FAIL sb_dut%0d: got sel=%0d addr=%0d data=%0d, expected sel=%0d addr=%0d data=%0d",
                         d, wr_sel[d], wr_addr[d], wr_data[d], it.sel, it.addr, it.data);
              end
            end
          end
          if (done[d]) done_cnt[d]++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return {7'd0, busy[d], done[d], err_mode[d], pass_v[d], wr_en[d],
            rd_sel[d], wr_sel[d], rd_addr[d], wr_addr[d], wr_data[d]};
  endfunction

  function automatic int at(input bit vert, input int l, input int k);
    return vert ? k * 4 + l : l * 4 + k;
  endfunction

  function automatic int f3(input int a, input int b, input int c, input int rnd);
    return (a + 2 * b + c + 2 * rnd) >> 2;
  endfunction

  // engine d rounds iff d == 1
  task automatic model_pass(input int d, input bit vert, input img_t src,
                            input logic [1:0] sel, output img_t dst);
    int a, km, kp;
    sb_t it;
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++) begin
        km = (k == 0) ? 0 : k - 1;
        kp = (k == 3) ? 3 : k + 1;
        a = at(vert, l, k);
        dst[a] = 8'(f3(src[at(vert, l, km)], src[a], src[at(vert, l, kp)], d));
        it = {sel, 4'(a), dst[a]};
        q[d].push_back(it);
      end
  endtask

  task automatic expect_run(input logic [1:0] m);
    img_t t, u;
    for (int d = 0; d < 2; d++)
      case (m)
        2'd0:    model_pass(d, 1'b0, img, 2'd2, t);
        2'd1:    model_pass(d, 1'b1, img, 2'd2, t);
        default: begin
          model_pass(d, 1'b0, img, 2'd1, t);
          model_pass(d, 1'b1, t, 2'd2, u);
        end
      endcase
  endtask

  // exp0/exp1 > 0: exact start-to-done cycles; poke > 0: stray start while busy
  task automatic run(input logic [1:0] m, input int exp0, input int exp1, input int poke);
    int n, got0, got1;
    expect_run(m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    n = 0; got0 = 0; got1 = 0;
    while ((got0 == 0 || got1 == 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke);
      mode  = 2'd3;
      if (done[0] && got0 == 0) got0 = n;
      if (done[1] && got1 == 0) got1 = n;
    end
    start = 1'b0;
    if (exp0 > 0) begin
      chk("cycles_dut0", got0, exp0);
      chk("cycles_dut1", got1, exp1);
    end else begin
      chk("done_seen_dut0", int'(got0 > 0), 1);
      chk("done_seen_dut1", int'(got1 > 0), 1);
    end
    chk("err_mode_clear", int'(err_mode), 0);
    chk("sb_drained_dut0", q[0].size(), 0);
    chk("sb_drained_dut1", q[1].size(), 0);
  endtask

  task automatic chk_line(input string name, input int d, input int sel, input int base,
                          input int stride, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) chk(name, int'(mem[d][sel][base + i * stride]), e[i]);
  endtask

  initial begin : stim
    int n, dc0, dc1;
    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_dut0", int'(outs(0)), 0);
    chk("reset_outs_dut1", int'(outs(1)), 0);
    rst = 1'b1;

    // H only: 29 / 37 cycles start to done
    img = '{10, 20, 30, 40, 0, 255, 0, 255, 5, 5, 5, 5, 100, 50, 25, 0};
    run(2'd0, 29, 37, 0);
    chk_line("h_row0_dut0", 0, 2, 0, 1, 12, 20, 30, 37);
    chk_line("h_row0_dut1", 1, 2, 0, 1, 13, 20, 30, 38);

    for (int i = 0; i < 16; i++) img[i] = 8'd255;
    run(2'd0, 29, 37, 0);
    chk("sat255_dut0", int'(mem[0][2][5]), 255);
    chk("sat255_dut1", int'(mem[1][2][15]), 255);
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    run(2'd0, 29, 37, 0);
    chk("zero_dut1", int'(mem[1][2][0]), 0);

    // H then V on a single bright pixel at (1,1)
    img[5] = 8'd255;
    run(2'd2, 0, 0, 0);
    chk_line("hv_tmp_dut0", 0, 1, 4, 1, 63, 127, 63, 0);
    chk("hv_tmp_row0_dut0", int'(mem[0][1][1]), 0);
    chk_line("hv_out_dut0", 0, 2, 1, 4, 31, 63, 31, 0);
    chk_line("hv_tmp_dut1", 1, 1, 4, 1, 64, 128, 64, 0);
    chk_line("hv_out_dut1", 1, 2, 1, 4, 32, 64, 32, 0);

    // V only on the transposed image
    img = '{10, 0, 5, 100, 20, 255, 5, 50, 30, 0, 5, 25, 40, 255, 5, 0};
    run(2'd1, 29, 37, 0);
    chk_line("v_col0_dut0", 0, 2, 0, 4, 12, 20, 30, 37);
    chk_line("v_col0_dut1", 1, 2, 0, 4, 13, 20, 30, 38);

    // abort once engine 0 is writing line 2
    img = '{10, 20, 30, 40, 0, 255, 0, 255, 5, 5, 5, 5, 100, 50, 25, 0};
    expect_run(2'd0);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(wr_en[0] && wr_addr[0][3:2] == 2'd2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_line2", int'(n < 200), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    q[0].delete();
    q[1].delete();
    dc0 = done_cnt[0];
    dc1 = done_cnt[1];
    chk("abort_busy", int'(busy), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", (done_cnt[0] - dc0) + (done_cnt[1] - dc1), 0);
    run(2'd0, 29, 37, 0);

    // illegal mode: done + err_mode for one cycle, err_mode then sticks
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", int'({done, err_mode, busy}), 6'b111111);
    @(posedge clk); #1;
    chk("err_sticky", int'({done, err_mode, busy}), 6'b001100);

    // stray start with mode 3 mid-run is ignored
    run(2'd0, 29, 37, 5);
    chk_line("restart_row0_dut0", 0, 2, 0, 1, 12, 20, 30, 37);

    // asynchronous reset mid-pass
    expect_run(2'd0);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midpass_busy", int'(busy), 3);
    rst = 1'b0;
    #1;
    chk("rst_outs_dut0", int'(outs(0)), 0);
    chk("rst_outs_dut1", int'(outs(1)), 0);
    q[0].delete();
    q[1].delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/gauss3_sep_engine.md
Name: gauss3_sep_engine

Overview:
- Parametrised separable 3-tap Gaussian (1-2-1)/4 filter engine for frame buffers held in block RAM.
- Runs a horizontal pass, a vertical pass, or both in sequence (H into the intermediate buffer, then V into the output buffer).
- Uses a sliding 3-tap window, so each pixel is read once per pass. Borders use edge replication.
- Sits between the display-side image BRAMs and the button/state control logic; the VGA path reads results once done is seen.

Parameters:
PIX_W, 8, pixel width in bits
COL_W, 7, log2 of image width (image width W = 2**COL_W)
ROW_W, 7, log2 of image height (image height H = 2**ROW_W)
RD_LAT, 1, read latency of the source BRAM in cycles (1..3)
ROUND, 0, 0 = truncate; 1 = add 2 before the shift (round half up)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; sampled only in IDLE
mode  in  2  0 = H only, 1 = V only, 2 = H then V, 3 = illegal
abort  in  1  cancels the current operation
busy  out  1  high from the cycle after start until DONE is left
done  out  1  one-cycle pulse on successful completion
err_mode  out  1  set when start arrives with mode 3; cleared by the next start
pass_v  out  1  0 = H pass active, 1 = V pass active
rd_sel  out  2  buffer select: 0 = input, 1 = intermediate, 2 = output
rd_addr  out  ROW_W+COL_W  read address, formed as {row,col}
rd_data  in  PIX_W  read data, valid RD_LAT cycles after rd_addr
wr_en  out  1  write strobe
wr_sel  out  2  destination buffer select
wr_addr  out  ROW_W+COL_W  write address, formed as {row,col}
wr_data  out  PIX_W  filtered pixel

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs are 0, including busy, done, err_mode, pass_v, wr_en, wr_addr, wr_data, rd_addr and rd_sel.
- States and transitions:
  - IDLE:
    - start with mode 0 or 2 → HPASS.
    - start with mode 1 → VPASS.
    - start with mode 3 → ERR.
  - HPASS: after the last line → VPASS if mode = 2, otherwise DONE.
  - VPASS: after the last line → DONE.
  - DONE: one cycle, done = 1, then IDLE.
  - ERR: one cycle, done = 1 and err_mode = 1, then IDLE.
- mode is latched on start. Changes to mode while busy are ignored, and start while busy is ignored.
- Buffer routing:
  - mode 0 and mode 1: read sel 0, write sel 2.
  - mode 2, HPASS: read sel 0, write sel 1.
  - mode 2, VPASS: read sel 1, write sel 2.
- Scan order:
  - A "line" is a row in HPASS and a column in VPASS; line length N is W or H respectively.
  - HPASS processes rows 0..H-1 in order; VPASS processes columns 0..W-1 in order.
- Line timing, with t0 = the first read of the line:
  - Read of index j (0..N-1) is issued at t0+j.
  - The write for index k is asserted at t0+RD_LAT+k+2, giving N contiguous writes per line.
  - The next line's t0 is the previous t0 + N+RD_LAT+2, so there is no overlap between lines.
  - The first line's t0 is the cycle after the state is entered.
- Window and arithmetic:
  - The window is a,b,c = pixel[k-1], pixel[k], pixel[k+1].
  - Edge replication: pixel[-1] = pixel[0], and pixel[N] = pixel[N-1].
  - sum = a + 2b + c, computed at PIX_W+2 bits; it cannot overflow.
  - out = (sum + 2*ROUND) >> 2. The result always fits in PIX_W bits, because the maximum is (4*(2**PIX_W-1)+2)>>2.
- Addresses: all address arithmetic stays inside [0, N-1]. There is no wrap-around and no negative index.
- abort:
  - In HPASS or VPASS, the next state is IDLE.
  - wr_en is 0 from the cycle after abort is sampled, and no done pulse is issued.
  - In-flight read data is discarded.
- err_mode: sticky until the next accepted start.
- busy = 1 in HPASS, VPASS, DONE and ERR.
- Simultaneous events: abort wins over a line or pass completion in the same cycle.
- Total cycles, start to done:
  - Single pass: H·(W+RD_LAT+2)+1 for H only, W·(H+RD_LAT+2)+1 for V only.
  - mode 2: the sum of both passes.

Decomposition:
- Shared package (gauss_pkg):
  - State encoding: IDLE, HPASS, VPASS, DONE, ERR.
  - Mode constants MODE_H=0, MODE_V=1, MODE_HV=2.
  - Buffer-select constants BUF_IN=0, BUF_TMP=1, BUF_OUT=2.
- Sub-module gauss3_tap:
  - Holds the 3-entry window shift register, edge-replication control (first/last flags) and the 1-2-1 adder with ROUND.
  - One output register; reused by both passes.
- The top level holds the FSM, the line/index counters, the RD_LAT-deep valid pipeline, and address/select generation.

Test Plan:
- COL_W=ROW_W=2, RD_LAT=1, ROUND=0, mode 0, row 0 = [10,20,30,40] → wr_data for row 0 = [12,20,30,37] at addresses 0..3, sel 2. Done occurs 4·7+1 = 29 cycles after start.
- Same setup with ROUND=1 → [13,20,30,38]. An all-255 image gives all 255, and an all-0 image gives all 0.
- mode 2 with a single 255 at (1,1), rest 0 → tmp buffer row 1 = [63,127,63,0], other rows 0. Output column 1 = [31,63,31,0].
- RD_LAT=3, mode 1 → same results as the RD_LAT=1 run, with the line period = 4+3+2 = 9 cycles.
- abort asserted mid-HPASS at line 2 → no wr_en after the next cycle, no done pulse, busy = 0 within 2 cycles. A subsequent start runs to completion normally.
- Start with mode 3 → done and err_mode the next cycle, no wr_en. Start while busy is ignored. Asserting rst mid-pass → all outputs are 0 immediately.
